// File: rtl/cacheline_burst_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_burst_adaptor
//
// Bridges the cache's 256-bit line interface to a 64-bit burst memory port.
// A dirty-line writeback is serialised into four beats; a line fill is
// assembled from four beats. Cache control gets a one-cycle resp_o pulse
// when the transaction finishes.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   address_i  line address from the cache datapath
//   line_i     line to write back
//   read_i     line fill request
//   write_i    writeback request (wins over read_i)
//   line_o     assembled fill line
//   resp_o     one-cycle completion pulse
//   err_o      transaction aborted by the watchdog
//   address_o  line-aligned memory address, held for the transaction
//   burst_o    write beat data
//   read_o     memory read request
//   write_o    memory write request
//   burst_i    read beat data
//   resp_i     memory beat acknowledge, one per beat
//
// Optional feature: define CACHELINE_BURST_ADAPTOR_TIMEOUT_EN to enable a
// stall watchdog that aborts a burst after timeout_cycles consecutive
// cycles without resp_i. Without it err_o is tied low and the adaptor
// waits indefinitely.
// ---------------------------------------------------------------------------
module cacheline_burst_adaptor #(
    parameter int s_line         = 256,
    parameter int s_burst        = 64,
    parameter int s_offset       = 5,
    parameter int timeout_cycles = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         address_i,
    input  logic [s_line-1:0]   line_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic [s_line-1:0]   line_o,
    output logic                resp_o,
    output logic                err_o,
    output logic [31:0]         address_o,
    output logic [s_burst-1:0]  burst_o,
    output logic                read_o,
    output logic                write_o,
    input  logic [s_burst-1:0]  burst_i,
    input  logic                resp_i
);

    localparam int n_beats = s_line / s_burst;
    localparam int cnt_w   = $clog2(n_beats);
    // Masking (rather than slicing) keeps every address bit in use.
    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [cnt_w-1:0]   cnt_reg;
    logic [s_burst-1:0] wbuf_reg  [n_beats];
    logic [s_burst-1:0] fill_reg  [n_beats];

    logic in_burst;
    logic beat_ack;
    logic last_beat;
    logic start_txn;
    logic timeout_hit;

    assign in_burst  = (state_reg == RD) || (state_reg == WR);
    assign beat_ack  = in_burst && resp_i;
    assign last_beat = beat_ack && (cnt_reg == cnt_w'(n_beats - 1));
    assign start_txn = (state_reg == IDLE) && (read_i || write_i);

`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
    logic [7:0] stall_cnt_reg;
    logic       err_reg;

    // Fires on the timeout_cycles-th consecutive stalled cycle.
    assign timeout_hit = in_burst && !resp_i &&
                         (stall_cnt_reg == 8'(timeout_cycles - 1));

    // The counter is held at zero outside a burst, so it starts clean on
    // every entry to RD/WR. err_reg lines up with the DONE cycle that
    // follows an abort and is low otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= timeout_hit;
            if (!in_burst || resp_i || timeout_hit)
                stall_cnt_reg <= '0;
            else
                stall_cnt_reg <= stall_cnt_reg + 8'd1;
        end
    end

    assign err_o = err_reg && (state_reg == DONE);
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (write_i)
                    state_next = WR;
                else if (read_i)
                    state_next = RD;
            end
            RD, WR: begin
                if (last_beat || timeout_hit)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        case (state_reg)
            RD: read_o = 1'b1;
            WR: begin
                write_o = 1'b1;
                burst_o = wbuf_reg[cnt_reg];
            end
            DONE:    resp_o = 1'b1;
            default: ;
        endcase
    end

    // Beat counter; cleared while idle so an aborted burst cannot leak
    // its position into the next transaction. Wraps naturally on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_reg <= '0;
        else if (state_reg == IDLE)
            cnt_reg <= '0;
        else if (beat_ack)
            cnt_reg <= cnt_reg + 1'b1;
    end

    // Address is captured once per transaction and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            address_o <= '0;
        else if (start_txn)
            address_o <= address_i & addr_mask;
    end

    // Per-beat storage: writeback buffer slices and fill line slices.
    // Beats are little-endian, beat 0 occupying the low bits.
    genvar gi;
    generate
        for (gi = 0; gi < n_beats; gi++) begin : g_beat
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    wbuf_reg[gi] <= '0;
                else if ((state_reg == IDLE) && write_i)
                    wbuf_reg[gi] <= line_i[gi*s_burst +: s_burst];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    fill_reg[gi] <= '0;
                else if ((state_reg == RD) && resp_i && (cnt_reg == cnt_w'(gi)))
                    fill_reg[gi] <= burst_i;
            end

            assign line_o[gi*s_burst +: s_burst] = fill_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  address_i;
    logic [255:0] line_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic         err_o;
    logic [31:0]  address_o;
    logic [63:0]  burst_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int n_checks = 0;
    int n_fail   = 0;

    cacheline_burst_adaptor #(
        .s_line(256), .s_burst(64), .s_offset(5), .timeout_cycles(8)
    ) dut (
        .clk(clk), .rst(rst), .address_i(address_i), .line_i(line_i),
        .read_i(read_i), .write_i(write_i), .line_o(line_o), .resp_o(resp_o),
        .err_o(err_o), .address_o(address_o), .burst_o(burst_o),
        .read_o(read_o), .write_o(write_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; address_i = '0; line_i = '0; read_i = 1'b0;
        write_i = 1'b0; burst_i = '0; resp_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({read_o, write_o, resp_o, err_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {read_o, write_o, resp_o, err_o});
        end
        n_checks++;
        if (line_o !== 256'd0) begin
            n_fail++; $display("FAIL reset_line: got %h expected 0", line_o);
        end
        n_checks++;
        if (address_o !== 32'd0 || burst_o !== 64'd0) begin
            n_fail++; $display("FAIL reset_addr_burst: got %h/%h expected 0/0", address_o, burst_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1;
            tick();
            n_checks++;
            if ({read_o, write_o, resp_o, err_o} !== 4'b0000 || line_o !== 256'd0) begin
                n_fail++; $display("FAIL idle_resp_ignored: got ctrl %b line %h expected 0000/0",
                                   {read_o, write_o, resp_o, err_o}, line_o);
            end
        end
        resp_i = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_fill();
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        beats[0] = 64'h1111_1111_1111_1111; beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333; beats[3] = 64'h4444_4444_4444_4444;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        address_i = 32'h0000_1234;
        read_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (read_o !== 1'b1 || resp_o !== 1'b0 || write_o !== 1'b0) begin
                n_fail++; $display("FAIL fill_beat%0d_ctrl: got rd %b wr %b resp %b expected 1 0 0",
                                   i, read_o, write_o, resp_o);
            end
            if (i == 0) begin
                n_checks++;
                if (address_o !== 32'h0000_1220) begin
                    n_fail++; $display("FAIL fill_addr: got %h expected 00001220", address_o);
                end
            end
            burst_i = beats[i];
            resp_i = 1'b1;
        end
        tick();
        n_checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0) begin
            n_fail++; $display("FAIL fill_done: got resp %b rd %b expected 1 0", resp_o, read_o);
        end
        n_checks++;
        if (line_o !== exp_line) begin
            n_fail++; $display("FAIL fill_line: got %h expected %h", line_o, exp_line);
        end
        read_i = 1'b0; resp_i = 1'b0; address_i = 32'hFFFF_FFFF; burst_i = '1;
        tick();
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || line_o !== exp_line || address_o !== 32'h0000_1220) begin
            n_fail++; $display("FAIL fill_hold: got resp %b rd %b line %h addr %h expected 0 0 held",
                               resp_o, read_o, line_o, address_o);
        end
        $display("test_fill done");
    endtask

    task automatic test_writeback_stalls();
        logic [63:0] wb [4];
        logic        pat [7];
        int          exp_idx [7];
        int          acks;
        int          resps;
        wb[0] = 64'hDEAD_BEEF_0000_000A; wb[1] = 64'hDEAD_BEEF_0000_000B;
        wb[2] = 64'hDEAD_BEEF_0000_000C; wb[3] = 64'hDEAD_BEEF_0000_000D;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_idx = '{0, 1, 1, 1, 2, 3, 3};
        acks = 0;
        line_i = {wb[3], wb[2], wb[1], wb[0]};
        address_i = 32'h0000_ABCF;
        write_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) begin
                line_i = '1;
                address_i = 32'h0;
            end
            n_checks++;
            if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== wb[exp_idx[i]] || address_o !== 32'h0000_ABC0) begin
                n_fail++; $display("FAIL wb_cycle%0d: got wr %b rd %b burst %h addr %h expected 1 0 %h 0000abc0",
                                   i, write_o, read_o, burst_o, address_o, wb[exp_idx[i]]);
            end
            resp_i = pat[i];
            if (write_o && resp_i) acks++;
        end
        tick();
        n_checks++;
        if (resp_o !== 1'b1 || write_o !== 1'b0) begin
            n_fail++; $display("FAIL wb_done: got resp %b wr %b expected 1 0", resp_o, write_o);
        end
        resps = int'(resp_o);
        write_i = 1'b0; resp_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            resps += int'(resp_o);
        end
        n_checks++;
        if (acks !== 4 || resps !== 1) begin
            n_fail++; $display("FAIL wb_counts: got acks %0d resps %0d expected 4 1", acks, resps);
        end
        $display("test_writeback_stalls done");
    endtask

    task automatic test_priority();
        logic [63:0]  fb [4];
        logic [255:0] exp_line;
        fb[0] = 64'hA0A0_A0A0_A0A0_A0A0; fb[1] = 64'hB1B1_B1B1_B1B1_B1B1;
        fb[2] = 64'hC2C2_C2C2_C2C2_C2C2; fb[3] = 64'hD3D3_D3D3_D3D3_D3D3;
        exp_line = {fb[3], fb[2], fb[1], fb[0]};
        line_i = {4{64'h0123_4567_89AB_CDEF}};
        address_i = 32'h0000_0040;
        read_i = 1'b1; write_i = 1'b1;
        tick();
        n_checks++;
        if (write_o !== 1'b1 || read_o !== 1'b0) begin
            n_fail++; $display("FAIL prio_write_first: got wr %b rd %b expected 1 0", write_o, read_o);
        end
        resp_i = 1'b1;
        for (int k = 0; k < 10 && !resp_o; k++) tick();
        n_checks++;
        if (resp_o !== 1'b1) begin
            n_fail++; $display("FAIL prio_wr_resp: got %b expected 1 within bound", resp_o);
        end
        write_i = 1'b0;
        tick();
        n_checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
            n_fail++; $display("FAIL prio_idle_gap: got rd %b wr %b resp %b expected 0 0 0", read_o, write_o, resp_o);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (read_o !== 1'b1 || write_o !== 1'b0) begin
                n_fail++; $display("FAIL prio_rd_beat%0d: got rd %b wr %b expected 1 0", i, read_o, write_o);
            end
            burst_i = fb[i];
            resp_i = 1'b1;
            tick();
        end
        n_checks++;
        if (resp_o !== 1'b1 || line_o !== exp_line) begin
            n_fail++; $display("FAIL prio_rd_done: got resp %b line %h expected 1 %h", resp_o, line_o, exp_line);
        end
        read_i = 1'b0; resp_i = 1'b0;
        tick();
        $display("test_priority done");
    endtask

    task automatic test_async_reset();
        logic [63:0] s0, s1;
        logic [63:0] nb [4];
        s0 = 64'h5A5A_5A5A_5A5A_5A5A; s1 = 64'h6B6B_6B6B_6B6B_6B6B;
        nb[0] = 64'h0F0F_0000_0000_0001; nb[1] = 64'h0F0F_0000_0000_0002;
        nb[2] = 64'h0F0F_0000_0000_0003; nb[3] = 64'h0F0F_0000_0000_0004;
        address_i = 32'h0000_2000;
        read_i = 1'b1;
        tick();
        burst_i = s0; resp_i = 1'b1;
        tick();
        burst_i = s1;
        tick();
        resp_i = 1'b0;
        n_checks++;
        if (line_o[127:0] !== {s1, s0}) begin
            n_fail++; $display("FAIL ar_partial: got %h expected %h", line_o[127:0], {s1, s0});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({read_o, write_o, resp_o, err_o} !== 4'b0000 || line_o !== 256'd0 ||
            address_o !== 32'd0 || burst_o !== 64'd0) begin
            n_fail++; $display("FAIL ar_clear: got ctrl %b line %h addr %h burst %h expected all 0",
                               {read_o, write_o, resp_o, err_o}, line_o, address_o, burst_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        address_i = 32'h0000_3010;
        tick();
        n_checks++;
        if (read_o !== 1'b1 || address_o !== 32'h0000_3000) begin
            n_fail++; $display("FAIL ar_restart: got rd %b addr %h expected 1 00003000", read_o, address_o);
        end
        burst_i = nb[0]; resp_i = 1'b1;
        tick();
        n_checks++;
        if (line_o !== {192'd0, nb[0]}) begin
            n_fail++; $display("FAIL ar_beat0: got %h expected %h", line_o, {192'd0, nb[0]});
        end
        for (int i = 1; i < 4; i++) begin
            burst_i = nb[i];
            tick();
        end
        n_checks++;
        if (resp_o !== 1'b1 || line_o !== {nb[3], nb[2], nb[1], nb[0]}) begin
            n_fail++; $display("FAIL ar_refill: got resp %b line %h expected 1 %h",
                               resp_o, line_o, {nb[3], nb[2], nb[1], nb[0]});
        end
        read_i = 1'b0; resp_i = 1'b0;
        tick();
        $display("test_async_reset done");
    endtask

    task automatic test_timeout();
        address_i = 32'h0000_0100;
        read_i = 1'b1; resp_i = 1'b0;
        tick();
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
        begin
            int n;
            n = 1;
            while (!resp_o && n < 40) begin
                tick();
                n++;
            end
            n_checks++;
            if (resp_o !== 1'b1 || err_o !== 1'b1 || read_o !== 1'b0 || n !== 9) begin
                n_fail++; $display("FAIL to_abort: got resp %b err %b rd %b cycle %0d expected 1 1 0 9",
                                   resp_o, err_o, read_o, n);
            end
            read_i = 1'b0;
            tick();
            n_checks++;
            if (resp_o !== 1'b0 || err_o !== 1'b0 || read_o !== 1'b0) begin
                n_fail++; $display("FAIL to_after: got resp %b err %b rd %b expected 0 0 0", resp_o, err_o, read_o);
            end
        end
`else
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 40; i++) begin
                if (read_o !== 1'b1 || err_o !== 1'b0 || resp_o !== 1'b0) bad++;
                tick();
            end
            n_checks++;
            if (bad !== 0) begin
                n_fail++; $display("FAIL to_wait: got %0d bad cycles expected 0 (rd %b err %b resp %b)",
                                   bad, read_o, err_o, resp_o);
            end
            read_i = 1'b0;
            rst = 1'b1;
            #1;
            n_checks++;
            if (read_o !== 1'b0 || err_o !== 1'b0) begin
                n_fail++; $display("FAIL to_reset_exit: got rd %b err %b expected 0 0", read_o, err_o);
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
`endif
        tick();
        $display("test_timeout done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_writeback_stalls();
        test_priority();
        test_async_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
